// File: rtl/vx_ibuffer_sched.sv
// Per-warp instruction buffer with a round-robin issue scheduler.
// One small FIFO per warp; the offered grant is held stable while issue stalls.
module vx_ibuffer_fifo #(
  parameter int DEPTH    = 2,
  parameter int DATAW    = 64,
  parameter int CNT_BITS = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                clr,
  input  logic [DATAW-1:0]    wdata,
  output logic [DATAW-1:0]    head,
  output logic [CNT_BITS-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // clr has priority: a flushed warp drops its same-cycle push and pop
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr && !reset) mem[wptr] <= wdata;
  end

  assign head = mem[rptr];
endmodule

module vx_ibuffer_sched #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 2,
  parameter int DATAW     = 64,
  parameter int NW_BITS   = $clog2(NUM_WARPS),
  parameter int CNT_BITS  = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [NW_BITS-1:0]   dec_wid,
  input  logic [DATAW-1:0]     dec_data,
  output logic                 dec_ready,
  output logic                 iss_valid,
  output logic [NW_BITS-1:0]   iss_wid,
  output logic [DATAW-1:0]     iss_data,
  input  logic                 iss_ready,
  input  logic                 flush,
  input  logic [NW_BITS-1:0]   flush_wid,
  output logic [NUM_WARPS-1:0] warp_empty
);
  logic [NUM_WARPS-1:0][CNT_BITS-1:0] count;
  logic [NUM_WARPS-1:0][DATAW-1:0]    head;
  logic [NUM_WARPS-1:0]               nonempty, push_v, pop_v, clr_v;
  logic [NW_BITS-1:0]                 rr_ptr, rr_grant, grant, lock_wid;
  logic                               lock, dec_fire, pop_en, flush_hit;

  assign dec_ready = (count[dec_wid] != CNT_BITS'(DEPTH));
  assign dec_fire  = dec_valid && dec_ready;

  genvar w;
  generate
    for (w = 0; w < NUM_WARPS; w++) begin : g_warp
      assign nonempty[w] = (count[w] != '0);
      assign clr_v[w]    = flush && (flush_wid == NW_BITS'(w));
      assign push_v[w]   = dec_fire && (dec_wid == NW_BITS'(w)) && !clr_v[w];
      assign pop_v[w]    = pop_en && (grant == NW_BITS'(w));
      vx_ibuffer_fifo #(.DEPTH(DEPTH), .DATAW(DATAW), .CNT_BITS(CNT_BITS)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_v[w]),
        .pop   (pop_v[w]),
        .clr   (clr_v[w]),
        .wdata (dec_data),
        .head  (head[w]),
        .count (count[w])
      );
    end
  endgenerate

  always_comb begin
    rr_grant = rr_ptr;
    for (int i = NUM_WARPS-1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_WARPS;
      if (nonempty[idx]) rr_grant = NW_BITS'(idx);
    end
  end

  assign grant      = lock ? lock_wid : rr_grant;
  assign iss_valid  = |nonempty;
  assign iss_wid    = grant;
  assign iss_data   = head[grant];
  assign warp_empty = ~nonempty;
  assign flush_hit  = flush && (flush_wid == grant);
  // a handshake on a warp being flushed is dropped along with the warp
  assign pop_en     = iss_valid && iss_ready && !flush_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_wid <= '0;
    end else begin
      if (pop_en) begin
        rr_ptr <= (grant == NW_BITS'(NUM_WARPS-1)) ? '0 : grant + 1'b1;
        lock   <= 1'b0;
      end else if (iss_valid && !iss_ready) begin
        lock     <= 1'b1;
        lock_wid <= grant;
      end
      if (flush_hit) lock <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vx_ibuffer_sched.sv
// Randomized bench for vx_ibuffer_sched against per-warp queue reference model.
module tb_vx_ibuffer_sched;
  localparam int NW = 4;
  localparam int D  = 2;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          dec_valid;
  logic [1:0]    dec_wid;
  logic [DW-1:0] dec_data;
  logic          dec_ready;
  logic          iss_valid;
  logic [1:0]    iss_wid;
  logic [DW-1:0] iss_data;
  logic          iss_ready;
  logic          flush;
  logic [1:0]    flush_wid;
  logic [NW-1:0] warp_empty;

  vx_ibuffer_sched #(.NUM_WARPS(NW), .DEPTH(D), .DATAW(DW)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_wid(dec_wid), .dec_data(dec_data), .dec_ready(dec_ready),
    .iss_valid(iss_valid), .iss_wid(iss_wid), .iss_data(iss_data), .iss_ready(iss_ready),
    .flush(flush), .flush_wid(flush_wid), .warp_empty(warp_empty)
  );

  always #5 clk = ~clk;

  // reference model: one queue of expected payloads per warp
  logic [DW-1:0] q [NW][$];
  int  rr = 0;
  bit  locked = 0;
  int  lock_w = 0;
  bit  model_ok = 0;
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (locked) return lock_w;
    for (int i = 0; i < NW; i++)
      if (q[(rr + i) % NW].size() > 0) return (rr + i) % NW;
    return -1;
  endfunction

  // monitor: checks outputs mid-cycle, then advances the model across the next posedge
  initial begin
    forever begin
      int  g;
      bit  v, pop, push;
      logic [NW-1:0] emp;
      @(negedge clk);
      #2;
      g = model_grant();
      v = (g >= 0);
      if (model_ok) begin
        chk("iss_valid", {63'b0, iss_valid}, {63'b0, v});
        if (v && iss_valid) begin
          chk("iss_wid", {62'b0, iss_wid}, DW'(g));
          chk("iss_data", iss_data, q[g][0]);
        end
        chk("dec_ready", {63'b0, dec_ready}, {63'b0, q[dec_wid].size() != D});
        for (int w = 0; w < NW; w++) emp[w] = (q[w].size() == 0);
        chk("warp_empty", {60'b0, warp_empty}, {60'b0, emp});
      end
      if (reset) begin
        for (int w = 0; w < NW; w++) q[w].delete();
        rr = 0; locked = 0; lock_w = 0;
        model_ok = 1;
      end else if (model_ok) begin
        pop  = v && iss_ready && !(flush && flush_wid == 2'(g));
        push = dec_valid && (q[dec_wid].size() != D) && !(flush && flush_wid == dec_wid);
        if (pop) begin
          void'(q[g].pop_front());
          rr = (g + 1) % NW;
          locked = 0;
        end else if (v && !iss_ready) begin
          locked = 1;
          lock_w = g;
        end
        if (flush) begin
          q[flush_wid].delete();
          if (locked && lock_w == int'(flush_wid)) locked = 0;
        end
        if (push) q[dec_wid].push_back(dec_data);
      end
    end
  end

  task automatic drive(input bit rst, input bit dv, input int wid, input logic [DW-1:0] data,
                       input bit ir, input bit fl, input int fw);
    reset     = rst;
    dec_valid = dv;
    dec_wid   = 2'(wid);
    dec_data  = data;
    iss_ready = ir;
    flush     = fl;
    flush_wid = 2'(fw);
    @(negedge clk);
  endtask

  task automatic idle(input bit ir, input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, ir, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, '0, 0, 0, 0);
    drive(1, 0, 0, '0, 0, 0, 0);
    idle(0, 1);
    // single push then issue
    drive(0, 1, 2, 64'hA5, 1, 0, 0);
    idle(1, 2);
    // fill W1 past capacity, pop, then retry
    drive(0, 1, 1, 64'h11, 0, 0, 0);
    drive(0, 1, 1, 64'h12, 0, 0, 0);
    drive(0, 1, 1, 64'h13, 0, 0, 0);
    drive(0, 0, 0, '0, 1, 0, 0);
    drive(0, 1, 1, 64'h13, 0, 0, 0);
    idle(1, 4);
    // round robin across warps 0,1,3
    for (int k = 0; k < 2; k++)
      foreach (q[w]) if (w != 2) drive(0, 1, w, 64'h100 + 64'(w * 16 + k), 0, 0, 0);
    idle(1, 7);
    // stall on W3, then W0 fills underneath
    drive(0, 1, 3, 64'h33, 0, 0, 0);
    idle(0, 1);
    drive(0, 1, 0, 64'h30, 0, 0, 0);
    idle(0, 2);
    idle(1, 3);
    // flush W1 with a concurrent push to W1
    drive(0, 1, 0, 64'h40, 0, 0, 0);
    drive(0, 1, 1, 64'h41, 0, 0, 0);
    drive(0, 1, 1, 64'h42, 0, 0, 0);
    drive(0, 1, 1, 64'h43, 0, 1, 1);
    idle(0, 1);
    idle(1, 3);
    // reset with three warps populated
    drive(0, 1, 0, 64'h50, 0, 0, 0);
    drive(0, 1, 2, 64'h52, 0, 0, 0);
    drive(0, 1, 3, 64'h53, 0, 0, 0);
    drive(1, 1, 1, 64'h51, 1, 0, 0);
    idle(0, 2);
    // randomized traffic with varying issue back-pressure
    for (int i = 0; i < 4000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 250) % 4) * 30 + 5;
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, NW-1)),
            {$urandom, $urandom},
            ($urandom_range(0, 99) < rdy_pct),
            ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, NW-1)));
    end
    idle(1, 10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
